// File: rtl/nlfsr_search_pkg.sv
// -----------------------------------------------------------------------------
// nlfsr_search_pkg
// Shared types and helpers for the NLFSR search engine:
//   - state_e        : engine FSM states
//   - TAP_W          : width of one tap index
//   - MAX_SIZE/MAX_TAPS : widest NLFSR / largest tap set the helper handles
//   - PRNG_POLY      : Galois feedback polynomial of the tap-drawing PRNG
//   - nlfsr_next()   : one NLFSR step for an arbitrary width and tap count
// -----------------------------------------------------------------------------
package nlfsr_search_pkg;

  localparam int TAP_W      = 8;
  localparam int MAX_SIZE   = 256;  // an 8-bit tap index addresses every bit
  localparam int MAX_TAPS   = 64;
  localparam int TAPS_BUS_W = MAX_TAPS * TAP_W;

  localparam logic [31:0] PRNG_POLY = 32'h80200003;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  // fb = s[0] ^ XOR_k (s[t2k] & s[t2k+1]); next = {fb, s[size-1:1]}.
  // The state is zero-padded above 'size', so a tap index >= size reads 0
  // and the right shift pulls a 0 into bit size-1 before fb overwrites it.
  function automatic logic [MAX_SIZE-1:0] nlfsr_next(
    input logic [MAX_SIZE-1:0]   s,
    input logic [TAPS_BUS_W-1:0] taps,
    input int                    size,
    input int                    num_taps
  );
    logic                  fb;
    logic [TAP_W-1:0]      ta;
    logic [TAP_W-1:0]      tb;
    logic [TAP_W-1:0]      msb;
    logic [MAX_SIZE-1:0]   nxt;
    fb  = s[0];
    for (int k = 0; k < MAX_TAPS / 2; k++) begin
      if (2 * k < num_taps) begin
        ta = taps[(2 * k) * TAP_W +: TAP_W];
        tb = taps[(2 * k + 1) * TAP_W +: TAP_W];
        fb = fb ^ (s[ta] & s[tb]);
      end
    end
    msb      = TAP_W'(size - 1);
    nxt      = s >> 1;
    nxt[msb] = fb;
    return nxt;
  endfunction

endpackage

// File: rtl/nlfsr_prng.sv
// -----------------------------------------------------------------------------
// nlfsr_prng
// 32-bit right-shifting Galois LFSR used to draw random tap indices.
// Ports:
//   clk  : clock, rising edge
//   res  : asynchronous active-low reset, reloads SEED
//   en   : advance one step this cycle
//   rnd  : low byte of the current LFSR state (candidate tap index)
// -----------------------------------------------------------------------------
module nlfsr_prng
  import nlfsr_search_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd13413515
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  output logic [TAP_W-1:0] rnd
);

  logic [31:0] lfsr;

  // PRNG_POLY has bit 31 set, so the step is invertible and a non-zero
  // seed never collapses to the all-zero lock-up state.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? PRNG_POLY : 32'h0);
    end
  end

  assign rnd = lfsr[TAP_W-1:0];

endmodule

// File: rtl/nlfsr_search_engine.sv
// -----------------------------------------------------------------------------
// nlfsr_search_engine
// Searches for maximal-period (2^SIZE-1) NLFSR tap sets. Tap sets are drawn
// from an internal PRNG (mode 0, repeated until a hit or the trial limit) or
// supplied by the host (mode 1, tested once). Each set is measured by
// clocking the NLFSR from state 1 until it returns or 2^SIZE-1 steps elapse.
// Ports:
//   clk, res          : clock (rising edge), asynchronous active-low reset
//   start, mode       : start pulse (IDLE only), search mode sampled with it
//   cfg_taps          : host tap set, tap k in bits [8k+7:8k]
//   abort             : synchronous return to IDLE, clears the result
//   busy              : engine not IDLE
//   exhausted         : sticky, trial limit reached; cleared by start
//   trial_count       : failed trials since start, saturating
//   res_valid/ready   : result handshake
//   res_found         : measured period is maximal
//   res_period        : measured period, 0 = no return to state 1
//   res_taps          : tap set of the result
// Limits: SIZE 4..255, NUM_OF_TAPS even, 2..MAX_TAPS.
// -----------------------------------------------------------------------------
module nlfsr_search_engine
  import nlfsr_search_pkg::*;
#(
  parameter int          SIZE        = 32,
  parameter int          NUM_OF_TAPS = 16,
  parameter logic [31:0] SEED        = 32'd13413515,
  parameter int          TRIAL_W     = 32,
  parameter int          MAX_TRIALS  = 0
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         start,
  input  logic                         mode,
  input  logic [NUM_OF_TAPS*TAP_W-1:0] cfg_taps,
  input  logic                         abort,
  output logic                         busy,
  output logic                         exhausted,
  output logic [TRIAL_W-1:0]           trial_count,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic                         res_found,
  output logic [SIZE-1:0]              res_period,
  output logic [NUM_OF_TAPS*TAP_W-1:0] res_taps
);

  localparam int                 TAPS_W      = NUM_OF_TAPS * TAP_W;
  localparam int                 IDX_W       = $clog2(NUM_OF_TAPS);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_OF_TAPS - 1);
  localparam logic [SIZE-1:0]    FULL_PERIOD = '1;
  localparam logic [SIZE-1:0]    ONE         = SIZE'(1);
  localparam logic [TAP_W-1:0]   TAP_MAX     = TAP_W'(SIZE - 1);
  localparam logic [TRIAL_W-1:0] TRIAL_LIMIT = TRIAL_W'(MAX_TRIALS);
  localparam logic [TRIAL_W-1:0] TRIAL_SAT   = '1;

  state_e              state;
  state_e              state_nxt;
  logic                mode_q;
  logic [TAPS_W-1:0]   taps;
  logic [IDX_W-1:0]    tap_idx;
  logic [SIZE-1:0]     s;
  logic [SIZE-1:0]     c;
  logic [SIZE-1:0]     s_next;
  logic [SIZE-1:0]     c_next;
  logic [TAP_W-1:0]    rnd;
  logic                prng_en;
  logic                accept;
  logic                returned;
  logic                full;
  logic                run_done;
  logic                found;
  logic                limit_hit;
  logic [TRIAL_W-1:0]  trial_inc;

  // The PRNG only moves while drawing; abort freezes it without reseeding.
  assign prng_en = (state == ST_DRAW) && !abort;

  nlfsr_prng #(
    .SEED (SEED)
  ) u_prng (
    .clk (clk),
    .res (res),
    .en  (prng_en),
    .rnd (rnd)
  );

  assign accept = (rnd != '0) && (rnd <= TAP_MAX);

  assign s_next   = SIZE'(nlfsr_next(MAX_SIZE'(s), TAPS_BUS_W'(taps), SIZE, NUM_OF_TAPS));
  assign c_next   = c + ONE;
  assign returned = (s_next == ONE);
  assign full     = (c_next == FULL_PERIOD);
  assign run_done = returned || full;
  assign found    = returned && full;

  assign trial_inc = (trial_count == TRIAL_SAT) ? trial_count : trial_count + TRIAL_W'(1);
  assign limit_hit = (MAX_TRIALS != 0) && (trial_inc == TRIAL_LIMIT);

  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_REPORT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = mode ? ST_RUN : ST_DRAW;
      ST_DRAW:   if (accept && (tap_idx == LAST_IDX)) state_nxt = ST_RUN;
      ST_RUN: begin
        if (run_done) begin
          if (found || mode_q) state_nxt = ST_REPORT;
          else if (limit_hit)  state_nxt = ST_IDLE;
          else                 state_nxt = ST_DRAW;
        end
      end
      ST_REPORT: if (res_ready) state_nxt = mode_q ? ST_IDLE : ST_DRAW;
      default:   state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Control and visible outputs.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= ST_IDLE;
      mode_q      <= 1'b0;
      exhausted   <= 1'b0;
      trial_count <= '0;
      res_found   <= 1'b0;
      res_period  <= '0;
      res_taps    <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        // An abort of live work discards it completely; an abort while IDLE
        // leaves a finished search (exhausted, trial_count) visible.
        if (state != ST_IDLE) begin
          trial_count <= '0;
          res_found   <= 1'b0;
          res_period  <= '0;
          res_taps    <= '0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              trial_count <= '0;
              exhausted   <= 1'b0;
              mode_q      <= mode;
            end
          end
          ST_RUN: begin
            if (run_done) begin
              if (found || mode_q) begin
                res_found  <= found;
                res_period <= returned ? c_next : '0;
                res_taps   <= taps;
              end else begin
                trial_count <= trial_inc;
                if (limit_hit) exhausted <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath: tap set under test, NLFSR state and step counter. These are
  // always initialised on entry to DRAW/RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && start && mode) begin
      taps <= cfg_taps;
    end else if ((state == ST_DRAW) && accept) begin
      taps[tap_idx*TAP_W +: TAP_W] <= rnd;
    end

    if ((state_nxt == ST_DRAW) && (state != ST_DRAW)) begin
      tap_idx <= '0;
    end else if ((state == ST_DRAW) && accept) begin
      tap_idx <= tap_idx + IDX_W'(1);
    end

    if ((state_nxt == ST_RUN) && (state != ST_RUN)) begin
      s <= ONE;
      c <= '0;
    end else if (state == ST_RUN) begin
      s <= s_next;
      c <= c_next;
    end
  end

endmodule

// File: tb/tb_nlfsr_search_engine.sv
// -----------------------------------------------------------------------------
// tb_nlfsr_search_engine
// Directed bench for nlfsr_search_engine with SIZE=4, NUM_OF_TAPS=2.
// dut_a: default SEED, unlimited trials. dut_b: SEED=4, MAX_TRIALS=1, whose
// first drawn set (taps 2,1) has period 4 and therefore fails.
// -----------------------------------------------------------------------------
module tb_nlfsr_search_engine;

  localparam int SZ = 4;
  localparam int NT = 2;
  localparam int TW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_res, a_start, a_mode, a_abort, a_busy, a_exh;
  logic            a_res_valid, a_res_ready, a_found;
  logic [NT*8-1:0] a_cfg, a_taps;
  logic [TW-1:0]   a_trials;
  logic [SZ-1:0]   a_period;

  logic            b_res, b_start, b_mode, b_abort, b_busy, b_exh;
  logic            b_res_valid, b_res_ready, b_found;
  logic [NT*8-1:0] b_cfg, b_taps;
  logic [TW-1:0]   b_trials;
  logic [SZ-1:0]   b_period;

  nlfsr_search_engine #(
    .SIZE(SZ), .NUM_OF_TAPS(NT), .TRIAL_W(TW), .MAX_TRIALS(0)
  ) dut_a (
    .clk(clk), .res(a_res), .start(a_start), .mode(a_mode), .cfg_taps(a_cfg),
    .abort(a_abort), .busy(a_busy), .exhausted(a_exh), .trial_count(a_trials),
    .res_valid(a_res_valid), .res_ready(a_res_ready), .res_found(a_found),
    .res_period(a_period), .res_taps(a_taps)
  );

  nlfsr_search_engine #(
    .SIZE(SZ), .NUM_OF_TAPS(NT), .SEED(32'd4), .TRIAL_W(TW), .MAX_TRIALS(1)
  ) dut_b (
    .clk(clk), .res(b_res), .start(b_start), .mode(b_mode), .cfg_taps(b_cfg),
    .abort(b_abort), .busy(b_busy), .exhausted(b_exh), .trial_count(b_trials),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_found(b_found),
    .res_period(b_period), .res_taps(b_taps)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic m, input logic [NT*8-1:0] t);
    a_mode  = m;
    a_cfg   = t;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic wait_valid_a(input int budget, output int n);
    n = 0;
    while (!a_res_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Golden model of the tap-drawing PRNG and of a 4-bit, 2-tap NLFSR.
  function automatic logic [31:0] prng_model(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ 32'h80200003) : (q >> 1);
  endfunction

  function automatic int period_model(input int t0, input int t1);
    int x[4];
    int f;
    x = '{1, 0, 0, 0};
    for (int step = 1; step <= 15; step++) begin
      f    = x[0] ^ (x[t0] & x[t1]);
      x[0] = x[1];
      x[1] = x[2];
      x[2] = x[3];
      x[3] = f;
      if (x[0] == 1 && x[1] == 0 && x[2] == 0 && x[3] == 0) return step;
    end
    return 0;
  endfunction

  logic [7:0]  g_t0, g_t1;
  int          g_fails;
  logic [31:0] g_q;

  task automatic compute_golden();
    logic [7:0] b;
    int         cnt;
    g_q     = 32'd13413515;
    g_fails = 0;
    for (int tr = 0; tr < 2000; tr++) begin
      cnt = 0;
      while (cnt < 2) begin
        b = g_q[7:0];
        if (b >= 8'd1 && b <= 8'd3) begin
          if (cnt == 0) g_t0 = b;
          else          g_t1 = b;
          cnt++;
        end
        g_q = prng_model(g_q);
      end
      if (period_model(int'(g_t0), int'(g_t1)) == 15) break;
      g_fails++;
    end
  endtask

  task automatic run_random_a(input string tag);
    int n;
    a_res_ready = 1'b0;
    start_a(1'b0, '0);
    wait_valid_a(30000, n);
    check({tag, "_valid"},   a_res_valid, 1);
    check({tag, "_found"},   a_found, 1);
    check({tag, "_period"},  a_period, 15);
    check({tag, "_taps"},    a_taps, {g_t1, g_t0});
    check({tag, "_trials"},  a_trials, g_fails);
    check({tag, "_t0_range"}, (a_taps[7:0] >= 8'd1) && (a_taps[7:0] <= 8'd3), 1);
    check({tag, "_t1_range"}, (a_taps[15:8] >= 8'd1) && (a_taps[15:8] <= 8'd3), 1);
  endtask

  typedef struct {
    logic [15:0] taps;
    logic        found;
    int          period;
  } vec_t;

  vec_t vt[5];

  initial begin
    int  n;
    int  xfers;
    logic saw_valid;

    vt[0] = '{16'h0101, 1'b1, 15};  // x^4+x+1
    vt[1] = '{16'h0202, 1'b0, 6};   // x^4+x^2+1
    vt[2] = '{16'h0303, 1'b1, 15};  // x^4+x^3+1
    vt[3] = '{16'h0102, 1'b0, 4};   // s0 ^ s2&s1
    vt[4] = '{16'h0302, 1'b0, 4};   // s0 ^ s2&s3

    a_res = 1'b0; a_start = 1'b0; a_mode = 1'b0; a_cfg = '0; a_abort = 1'b0; a_res_ready = 1'b0;
    b_res = 1'b0; b_start = 1'b0; b_mode = 1'b0; b_cfg = '0; b_abort = 1'b0; b_res_ready = 1'b0;
    compute_golden();

    tick(); tick();
    check("rst_busy",      a_busy, 0);
    check("rst_exhausted", a_exh, 0);
    check("rst_trials",    a_trials, 0);
    check("rst_valid",     a_res_valid, 0);
    check("rst_found",     a_found, 0);
    check("rst_period",    a_period, 0);
    check("rst_taps",      a_taps, 0);
    check("rst_b_busy",    b_busy, 0);
    check("rst_b_exh",     b_exh, 0);
    check("rst_b_valid",   b_res_valid, 0);
    a_res = 1'b1;
    b_res = 1'b1;
    tick();

    // Host-supplied tap sets, one measurement each.
    for (int i = 0; i < 5; i++) begin
      a_res_ready = 1'b0;
      start_a(1'b1, vt[i].taps);
      check($sformatf("vec%0d_busy", i), a_busy, 1);
      wait_valid_a(40, n);
      check($sformatf("vec%0d_latency", i), n, vt[i].period);
      check($sformatf("vec%0d_found", i),   a_found, vt[i].found);
      check($sformatf("vec%0d_period", i),  a_period, vt[i].period);
      check($sformatf("vec%0d_taps", i),    a_taps, vt[i].taps);
      a_res_ready = 1'b1;
      tick();
      a_res_ready = 1'b0;
      check($sformatf("vec%0d_valid_drop", i), a_res_valid, 0);
      check($sformatf("vec%0d_idle", i),       a_busy, 0);
    end

    // Trial limit: first drawn set {2,1} fails after 3 DRAW + 4 RUN cycles.
    b_mode  = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    saw_valid = 1'b0;
    while (b_busy && n < 100) begin
      tick();
      n++;
      if (b_res_valid) saw_valid = 1'b1;
    end
    check("exh_cycles",    n, 7);
    check("exh_flag",      b_exh, 1);
    check("exh_busy",      b_busy, 0);
    check("exh_trials",    b_trials, 1);
    check("exh_no_valid",  saw_valid, 0);
    b_mode  = 1'b1;
    b_cfg   = 16'h0101;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("exh_cleared_by_start", b_exh, 0);
    check("exh_restart_busy",     b_busy, 1);
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;

    // Random search from the reset seed, then back-to-back DRAW and abort.
    run_random_a("rand1");
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
    check("b2b_draw_busy",  a_busy, 1);
    check("b2b_valid_drop", a_res_valid, 0);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("abort_draw_busy",   a_busy, 0);
    check("abort_draw_trials", a_trials, 0);
    check("abort_draw_found",  a_found, 0);
    check("abort_draw_period", a_period, 0);
    check("abort_draw_taps",   a_taps, 0);

    // Abort in RUN.
    start_a(1'b1, 16'h0101);
    tick(); tick(); tick();
    check("run_busy", a_busy, 1);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("abort_run_busy", a_busy, 0);
    repeat (20) tick();
    check("abort_run_no_valid", a_res_valid, 0);

    // Abort in REPORT drops the result without a transfer.
    a_res_ready = 1'b0;
    start_a(1'b1, 16'h0202);
    wait_valid_a(40, n);
    check("report_valid",  a_res_valid, 1);
    check("report_period", a_period, 6);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("abort_rep_valid",  a_res_valid, 0);
    check("abort_rep_busy",   a_busy, 0);
    check("abort_rep_found",  a_found, 0);
    check("abort_rep_period", a_period, 0);
    check("abort_rep_taps",   a_taps, 0);

    // Collector stalls for 10 cycles, then accepts exactly once.
    start_a(1'b1, 16'h0101);
    wait_valid_a(40, n);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("stall%0d_valid", k),  a_res_valid, 1);
      check($sformatf("stall%0d_found", k),  a_found, 1);
      check($sformatf("stall%0d_period", k), a_period, 15);
      check($sformatf("stall%0d_taps", k),   a_taps, 16'h0101);
    end
    a_res_ready = 1'b1;
    xfers = 0;
    for (int k = 0; k < 4; k++) begin
      if (a_res_valid && a_res_ready) xfers++;
      tick();
    end
    a_res_ready = 1'b0;
    check("stall_one_transfer", xfers, 1);
    check("stall_idle",         a_busy, 0);

    // Asynchronous reset mid-RUN; afterwards the PRNG restarts from SEED.
    start_a(1'b1, 16'h0101);
    tick(); tick(); tick();
    #2;
    a_res = 1'b0;
    #1;
    check("arst_busy",      a_busy, 0);
    check("arst_valid",     a_res_valid, 0);
    check("arst_exhausted", a_exh, 0);
    check("arst_trials",    a_trials, 0);
    check("arst_found",     a_found, 0);
    check("arst_period",    a_period, 0);
    check("arst_taps",      a_taps, 0);
    tick();
    a_res = 1'b1;
    tick();
    run_random_a("rand2");
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("final_idle", a_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nlfsr_search_engine.md
# nlfsr_search_engine

Parametrised successor of the single-shot NLFSR search module. It draws random tap sets from an internal PRNG or accepts a host-supplied set. It clocks an on-board NLFSR of runtime-fixed width SIZE to measure the cycle length from state 1, and reports maximal-period (2^SIZE−1) configurations through a valid/ready result port with a trial counter and trial limit. It sits between the host control logic and the result collector, replacing the PRNG/Selector/XORs/NLFSR chain.

## Interface
- SIZE, 32: NLFSR width, 4..255 (tap indices are 8-bit).
- NUM_OF_TAPS, 16: tap indices per set, even, ≥2.
- SEED, 13413515: PRNG reset value (32-bit, non-zero).
- TRIAL_W, 32: trial counter width.
- MAX_TRIALS, 0: failed trials before giving up; 0 = unlimited.
- clk  in  1  single clock, rising edge.
- res  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse, honoured only in IDLE.
- mode  in  1  sampled with start: 0 = random search, 1 = test cfg_taps once.
- cfg_taps  in  NUM_OF_TAPS*8  host tap set, tap k in bits [8k+7:8k].
- abort  in  1  synchronous return to IDLE from any state.
- busy  out  1  high when not IDLE.
- exhausted  out  1  sticky, set when MAX_TRIALS is reached; cleared by start.
- trial_count  out  TRIAL_W  failed trials since start, saturating.
- res_valid  out  1  result available.
- res_ready  in  1  collector accepts the result.
- res_found  out  1  period == 2^SIZE−1.
- res_period  out  SIZE  measured period; 0 = no return within 2^SIZE−1 steps.
- res_taps  out  NUM_OF_TAPS*8  tap set of the result.

## Operation
- Feedback: fb = s[0] ^ XOR over k<NUM_OF_TAPS/2 of (s[t2k] & s[t2k+1]). Equal indices give a linear term. Next state = {fb, s[SIZE-1:1]}.
- States: IDLE, DRAW, RUN, REPORT.
- IDLE, start: clear trial_count and exhausted, latch mode. Mode 0 goes to DRAW. Mode 1 loads cfg_taps and goes to RUN.
- DRAW: the PRNG advances every cycle. Its low byte b is accepted as the next tap if 1 ≤ b ≤ SIZE−1, otherwise rejected. After NUM_OF_TAPS accepts, go to RUN.
- RUN, entry: s = 1, step counter c = 0. Each cycle apply one step and increment c. Check the new state:
  - new state == 1 and c == 2^SIZE−1: found.
  - new state == 1 and c < 2^SIZE−1: fail, period = c.
  - c == 2^SIZE−1 and new state != 1: fail, period = 0.
- RUN outcome, found: go to REPORT.
- RUN outcome, fail in mode 1: go to REPORT.
- RUN outcome, fail in mode 0: increment trial_count. If trial_count reaches MAX_TRIALS (MAX_TRIALS ≠ 0), set exhausted and go to IDLE. Otherwise go to DRAW.
- REPORT: res_valid = 1 and the res_* fields are stable. The transfer occurs on res_valid & res_ready. Then mode 0 resumes DRAW and mode 1 goes to IDLE.
- abort wins over every other event in the same cycle. It drops res_valid without a transfer. The PRNG state is kept (it is not reseeded).
- start while busy is ignored.
- res deasserted mid-run: all state returns to reset values immediately. The PRNG reloads SEED.

## Timing
- Reset values: busy 0, exhausted 0, trial_count 0, res_valid 0, res_found 0, res_period 0, res_taps 0. Internal state IDLE, PRNG = SEED.
- start to busy: 1 cycle.
- DRAW lasts ≥ NUM_OF_TAPS cycles.
- RUN lasts exactly period cycles, or 2^SIZE−1 cycles on no-return.
- res_valid rises the cycle after the deciding RUN cycle.
- Back-to-back: DRAW starts the cycle after the handshake.

## Structure
- Package nlfsr_search_pkg:
  - state enum.
  - TAP_W = 8.
  - PRNG polynomial constant 32'h80200003.
  - function nlfsr_next(state, taps).
- Sub-module nlfsr_prng: 32-bit Galois LFSR with enable, SEED parameter and async active-low reset. It is the only instance.

## Test plan
- SIZE=4, NUM_OF_TAPS=2, mode 1, cfg_taps={1,1} (x^4+x+1) → after 15 RUN cycles: res_valid, res_found=1, res_period=15.
- Same config, cfg_taps={2,2} → res_found=0, res_period=6, res_valid 6 cycles after RUN entry, then IDLE.
- SIZE=4, mode 0, MAX_TRIALS=0 → first result has res_found=1 and res_period=15. All reported taps are in 1..3. trial_count equals the golden-model count of failures.
- SIZE=4, MAX_TRIALS=1, PRNG forced so the first set fails → exhausted=1, busy=0, trial_count=1, no res_valid.
- res_ready held low for 10 cycles in REPORT → res_* stable throughout; exactly one transfer on release.
- abort in DRAW, RUN and REPORT, and res pulsed low mid-RUN → IDLE next cycle (abort) or immediately (reset). Outputs at the reset values listed above.
